// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between decode and the ALU sequencer.
//   req_*  : operation request (valid/ready, opcode, wide flag, operands)
//   rsp_*  : operation response (valid/ready, result, flags, error)
// master : requester side (decode); slave : sequencer side.
interface alu_sequencer_if #(
  parameter int unsigned ALU_WIDTH = 8,
  parameter int unsigned OP_WIDTH  = 5
);
  logic                     req_valid;
  logic                     req_ready;
  logic [OP_WIDTH-1:0]      req_opcode;
  logic                     req_wide;
  logic [2*ALU_WIDTH-1:0]   req_a;
  logic [2*ALU_WIDTH-1:0]   req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [2*ALU_WIDTH-1:0]   rsp_result;
  logic [7:0]               rsp_flags;
  logic                     rsp_error;

  modport master (
    output req_valid, req_opcode, req_wide, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
  );

  modport slave (
    input  req_valid, req_opcode, req_wide, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one to three passes through the 8-bit combinational ALU per
// request. Narrow ops take a single pass; wide ADD/SUB run LO and HI byte
// passes plus an INC/DEC fix-up pass when the low byte carries/borrows.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   bus (slave)           : request/response handshake bundle
//   alu_a/alu_b/alu_opcode: registered drive to the ALU (zero outside passes)
//   alu_out/alu_status    : ALU result and {S,Z,0,H,0,PV,N,C} status
module alu_sequencer #(
  parameter int unsigned ALU_WIDTH = 8,
  parameter int unsigned OP_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_sequencer_if.slave       bus,
  output logic [ALU_WIDTH-1:0] alu_a,
  output logic [ALU_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]  alu_opcode,
  input  logic [ALU_WIDTH-1:0] alu_out,
  input  logic [7:0]           alu_status
);

  localparam int unsigned DW = 2 * ALU_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_INC = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_DEC = OP_WIDTH'(13);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  wide_q, wide_d;
  logic [ALU_WIDTH-1:0]  a_hi_q, a_hi_d;
  logic [ALU_WIDTH-1:0]  b_hi_q, b_hi_d;
  logic [ALU_WIDTH-1:0]  lo_q, lo_d;
  logic [ALU_WIDTH-1:0]  hi_q, hi_d;
  logic                  c0_q, c0_d;
  logic                  c1_q, c1_d;
  logic                  h_q, h_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]         rsp_result_q, rsp_result_d;
  logic [7:0]            rsp_flags_q, rsp_flags_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [ALU_WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [ALU_WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic                  is_sub;
  logic                  cf;

  // Flags of a completed 16-bit ADD/SUB, derived from the full result.
  function automatic logic [7:0] wide_flags(
    input logic [DW-1:0] r,
    input logic          c,
    input logic          h,
    input logic          sub,
    input logic          a15,
    input logic          b15
  );
    logic r15;
    logic pv;
    r15 = r[DW-1];
    pv  = sub ? ((a15 != b15) && (r15 != a15))
              : ((a15 == b15) && (r15 != a15));
    return {r15, (r == '0), 1'b0, h, 1'b0, pv, sub, c};
  endfunction

  assign is_sub = (op_q == OP_SUB);

  // Next-state, capture and ALU drive; ALU drive is computed for the state
  // being entered so the registered ALU inputs line up with the pass cycle.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wide_d       = wide_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    h_d          = h_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_error_d  = rsp_error_q;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_op_d     = '0;
    cf           = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d   = bus.req_opcode;
          wide_d = bus.req_wide;
          a_hi_d = bus.req_a[DW-1:ALU_WIDTH];
          b_hi_d = bus.req_b[DW-1:ALU_WIDTH];
          if (bus.req_wide && (bus.req_opcode != OP_ADD) && (bus.req_opcode != OP_SUB)) begin
            state_d      = RESP;
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_error_d  = 1'b1;
          end else begin
            state_d  = LO;
            alu_a_d  = bus.req_a[ALU_WIDTH-1:0];
            alu_b_d  = bus.req_b[ALU_WIDTH-1:0];
            alu_op_d = bus.req_opcode;
          end
        end
      end

      LO: begin
        lo_d = alu_out;
        c0_d = alu_status[0];
        if (wide_q) begin
          state_d  = HI;
          alu_a_d  = a_hi_q;
          alu_b_d  = b_hi_q;
          alu_op_d = op_q;
        end else begin
          state_d      = RESP;
          rsp_result_d = {{ALU_WIDTH{1'b0}}, alu_out};
          rsp_flags_d  = alu_status;
          rsp_error_d  = 1'b0;
        end
      end

      HI: begin
        hi_d = alu_out;
        c1_d = alu_status[0];
        h_d  = alu_status[4];
        if (c0_q) begin
          // Low byte carried/borrowed: propagate into the high byte.
          state_d  = FIX;
          alu_a_d  = alu_out;
          alu_op_d = is_sub ? OP_DEC : OP_INC;
        end else begin
          state_d      = RESP;
          rsp_result_d = {alu_out, lo_q};
          rsp_flags_d  = wide_flags({alu_out, lo_q}, alu_status[0], alu_status[4],
                                    is_sub, a_hi_q[ALU_WIDTH-1], b_hi_q[ALU_WIDTH-1]);
          rsp_error_d  = 1'b0;
        end
      end

      FIX: begin
        // Fix-up wraps the high byte exactly when it was all-ones (INC) or zero (DEC).
        cf           = is_sub ? (hi_q == '0) : (hi_q == '1);
        state_d      = RESP;
        rsp_result_d = {alu_out, lo_q};
        rsp_flags_d  = wide_flags({alu_out, lo_q}, c1_q | cf, h_q,
                                  is_sub, a_hi_q[ALU_WIDTH-1], b_hi_q[ALU_WIDTH-1]);
        rsp_error_d  = 1'b0;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d      = IDLE;
          rsp_result_d = '0;
          rsp_flags_d  = '0;
          rsp_error_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      wide_q       <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      c0_q         <= 1'b0;
      c1_q         <= 1'b0;
      h_q          <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_error_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wide_q       <= wide_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      h_q          <= h_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_error_q  <= rsp_error_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_error  = rsp_error_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_opcode     = alu_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU attached.
// Expected results, flags and latencies are hand-computed constants.
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic [7:0]  alu_status;

  int checks;
  int errors;

  alu_sequencer_if #(.ALU_WIDTH(8), .OP_WIDTH(5)) ifc ();

  alu_sequencer #(.ALU_WIDTH(8), .OP_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_status (alu_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {status, out}, status = {S,Z,0,H,0,PV,N,C}.
  function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r9;
    logic [7:0] r;
    logic h, pv, n, c;
    r9 = '0; h = 1'b0; pv = 1'b0; n = 1'b0; c = 1'b0;
    case (op)
      5'd0: begin
        r9 = {1'b0, a} + {1'b0, b};
        h  = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
        pv = (a[7] == b[7]) && (r9[7] != a[7]);
        c  = r9[8];
      end
      5'd1: begin
        r9 = {1'b0, a} - {1'b0, b};
        h  = a[3:0] < b[3:0];
        pv = (a[7] != b[7]) && (r9[7] != a[7]);
        n  = 1'b1;
        c  = r9[8];
      end
      5'd4: begin
        r9 = {1'b0, a & b};
        h  = 1'b1;
        pv = ~^(a & b);
      end
      5'd12: begin
        r9 = {1'b0, a + 8'd1};
        h  = (a[3:0] == 4'hF);
        pv = (a == 8'h7F);
      end
      5'd13: begin
        r9 = {1'b0, a - 8'd1};
        h  = (a[3:0] == 4'h0);
        pv = (a == 8'h80);
        n  = 1'b1;
      end
      default: r9 = '0;
    endcase
    r = r9[7:0];
    return {r[7], (r == 8'h00), 1'b0, h, 1'b0, pv, n, c, r};
  endfunction

  always_comb begin
    {alu_status, alu_out} = alu_model(alu_opcode, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic send(input logic [4:0] op, input logic wide, input logic [15:0] a, input logic [15:0] b);
    int n;
    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_opcode = op;
    ifc.req_wide   = wide;
    ifc.req_a      = a;
    ifc.req_b      = b;
    n = 0;
    while (!ifc.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.req_ready) check("accept_timeout", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
  endtask

  // Cycles from the accept edge to the first cycle with rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!ifc.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ifc.rsp_valid) check("rsp_timeout", 32'(ifc.rsp_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic wide,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_r, input logic [7:0] exp_f,
                        input logic exp_e, input int exp_lat);
    int lat;
    send(op, wide, a, b);
    wait_rsp(lat);
    check({tag, "_result"}, 32'(ifc.rsp_result), 32'(exp_r));
    check({tag, "_flags"},  32'(ifc.rsp_flags),  32'(exp_f));
    check({tag, "_error"},  32'(ifc.rsp_error),  32'(exp_e));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, "_released"}, 32'(ifc.rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic stable;
    logic seen;
    checks = 0;
    errors = 0;
    reset          = 1'b1;
    ifc.req_valid  = 1'b0;
    ifc.req_opcode = '0;
    ifc.req_wide   = 1'b0;
    ifc.req_a      = '0;
    ifc.req_b      = '0;
    ifc.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(ifc.req_ready),  32'd1);
    check("rst_rsp_valid", 32'(ifc.rsp_valid),  32'd0);
    check("rst_result",    32'(ifc.rsp_result), 32'd0);
    check("rst_flags",     32'(ifc.rsp_flags),  32'd0);
    check("rst_error",     32'(ifc.rsp_error),  32'd0);
    check("rst_alu_a",     32'(alu_a),          32'd0);
    check("rst_alu_op",    32'(alu_opcode),     32'd0);
    reset = 1'b0;

    // Narrow ADD; high operand bytes must be ignored.
    send(5'd0, 1'b0, 16'hAB3C, 16'hCD0A);
    check("nadd_alu_a",  32'(alu_a),      32'h3C);
    check("nadd_alu_b",  32'(alu_b),      32'h0A);
    check("nadd_alu_op", 32'(alu_opcode), 32'd0);
    check("nadd_busy",   32'(ifc.req_ready), 32'd0);
    wait_rsp(lat);
    check("nadd_result",  32'(ifc.rsp_result), 32'h0046);
    check("nadd_flags",   32'(ifc.rsp_flags),  32'h10);
    check("nadd_latency", 32'(lat),            32'd2);
    check("nadd_alu_idle", 32'(alu_a),         32'd0);
    @(posedge clk);
    #1;

    run_op("nsub", 5'd1, 1'b0, 16'h0010, 16'h0020, 16'h00F0, 8'h83, 1'b0, 2);
    run_op("nand", 5'd4, 1'b0, 16'h00F0, 16'h000F, 16'h0000, 8'h54, 1'b0, 2);
    run_op("wfix",  5'd0, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 8'h00, 1'b0, 4);
    run_op("wwrap", 5'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 8'h41, 1'b0, 4);
    run_op("wnofix", 5'd0, 1'b1, 16'h1234, 16'h0101, 16'h1335, 8'h00, 1'b0, 3);
    run_op("wsub",  5'd1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 8'h06, 1'b0, 4);
    run_op("werr",  5'd4, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 8'h00, 1'b1, 1);

    // Backpressure: response held while a second request waits.
    ifc.rsp_ready = 1'b0;
    send(5'd0, 1'b0, 16'h0001, 16'h0002);
    ifc.req_valid  = 1'b1;
    ifc.req_opcode = 5'd1;
    ifc.req_wide   = 1'b0;
    ifc.req_a      = 16'h0009;
    ifc.req_b      = 16'h0004;
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'd2);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!ifc.rsp_valid || ifc.rsp_result !== 16'h0003 || ifc.rsp_flags !== 8'h00 || ifc.req_ready)
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_valid", 32'(ifc.rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    check("bp_next_accepted", 32'(ifc.req_ready), 32'd0);
    wait_rsp(lat);
    check("bp_next_result", 32'(ifc.rsp_result), 32'h0005);
    check("bp_next_flags",  32'(ifc.rsp_flags),  32'h02);
    @(posedge clk);
    #1;

    // Reset during the HI pass aborts the op.
    send(5'd0, 1'b1, 16'h12FF, 16'h0001);
    @(posedge clk);
    #1;
    check("abort_hi_alu_a", 32'(alu_a), 32'h12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rsp_valid", 32'(ifc.rsp_valid),  32'd0);
    check("abort_req_ready", 32'(ifc.req_ready),  32'd1);
    check("abort_alu_a",     32'(alu_a),          32'd0);
    check("abort_alu_op",    32'(alu_opcode),     32'd0);
    check("abort_result",    32'(ifc.rsp_result), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ifc.rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    run_op("recover", 5'd0, 1'b1, 16'h1234, 16'h0101, 16'h1335, 8'h00, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
